// File: rtl/vscale_hasti_arbiter.sv
// vscale_hasti_arbiter
//   N-master to 1-slave HASTI (AHB-lite subset) arbiter for the multicore build.
//   Address and data phases are pipelined, and masters are picked round-robin.
//   If a master's data phase completes while its next address phase is still
//   stalled by arbitration, that response is held in a per-master buffer.
//   The buffered response is released in the cycle the stalled address is accepted.
//
// Ports (master buses are packed, master i in slice i):
//   clk, reset               clock, synchronous active-high reset
//   m_haddr/hwrite/hsize/htrans/hwdata   per-master request inputs
//   m_hrdata/hready/hresp    per-master response outputs
//   s_*                      shared slave port (hburst/hmastlock/hprot constant)
//   grant_idx                master owning the current address phase (debug)
//
// Optional feature: define VSCALE_HASTI_ARB_WAIT_CNT_EN to add per-master
//   saturating stall counters (wait_cnt output, wait_cnt_clr input).
module vscale_hasti_arbiter #(
    parameter int N_MASTERS = 4,
    parameter int IDX_W     = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_MASTERS*32-1:0] m_haddr,
    input  logic [N_MASTERS-1:0]    m_hwrite,
    input  logic [N_MASTERS*3-1:0]  m_hsize,
    input  logic [N_MASTERS*2-1:0]  m_htrans,
    input  logic [N_MASTERS*32-1:0] m_hwdata,
    output logic [N_MASTERS*32-1:0] m_hrdata,
    output logic [N_MASTERS-1:0]    m_hready,
    output logic [N_MASTERS-1:0]    m_hresp,
    output logic [31:0]             s_haddr,
    output logic                    s_hwrite,
    output logic [2:0]              s_hsize,
    output logic [2:0]              s_hburst,
    output logic                    s_hmastlock,
    output logic [3:0]              s_hprot,
    output logic [1:0]              s_htrans,
    output logic [31:0]             s_hwdata,
    input  logic [31:0]             s_hrdata,
    input  logic                    s_hready,
    input  logic                    s_hresp,
    output logic [IDX_W-1:0]        grant_idx
`ifdef VSCALE_HASTI_ARB_WAIT_CNT_EN
    ,
    input  logic                    wait_cnt_clr,
    output logic [N_MASTERS*32-1:0] wait_cnt
`endif
);

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    logic [N_MASTERS-1:0] req;
    logic                 gnt_valid;
    logic [IDX_W-1:0]     gnt;
    logic                 accept;
    logic [N_MASTERS-1:0] live;
    logic [N_MASTERS-1:0] buf_cap;
    logic [N_MASTERS-1:0] hready;
    logic [31:0]          sel_addr;
    logic                 sel_write;
    logic [2:0]           sel_size;
    logic [31:0]          own_wdata;

    logic                 dp_valid_q, dp_valid_d;
    logic [IDX_W-1:0]     dp_owner_q, dp_owner_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [N_MASTERS-1:0] rsp_pending_q, rsp_pending_d;
    logic [N_MASTERS-1:0] rsp_err_q, rsp_err_d;
    logic [31:0]          rsp_data_q [N_MASTERS];
    logic [31:0]          rsp_data_d [N_MASTERS];
    logic [31:0]          haddr_q, haddr_d;
    logic                 hwrite_q, hwrite_d;
    logic [2:0]           hsize_q, hsize_d;

    // Round-robin pick: first requester at or after rr_ptr_q, with wrap.
    // cand is one bit wider so rr_ptr + k never overflows before the wrap.
    always_comb begin
        logic [IDX_W:0] cand;
        gnt_valid = 1'b0;
        gnt       = '0;
        cand      = '0;
        for (int unsigned i = 0; i < N_MASTERS; i++) begin
            req[i] = (m_htrans[2*i +: 2] == HTRANS_NONSEQ);
        end
        for (int unsigned k = 0; k < N_MASTERS; k++) begin
            cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(N_MASTERS)) begin
                cand = cand - (IDX_W+1)'(N_MASTERS);
            end
            if (!gnt_valid && req[cand[IDX_W-1:0]]) begin
                gnt_valid = 1'b1;
                gnt       = cand[IDX_W-1:0];
            end
        end
    end

    assign accept = gnt_valid && s_hready;

    always_comb begin
        sel_addr  = '0;
        sel_write = 1'b0;
        sel_size  = '0;
        own_wdata = '0;
        for (int unsigned i = 0; i < N_MASTERS; i++) begin
            if (gnt == IDX_W'(i)) begin
                sel_addr  = m_haddr[32*i +: 32];
                sel_write = m_hwrite[i];
                sel_size  = m_hsize[3*i +: 3];
            end
            if (dp_owner_q == IDX_W'(i)) begin
                own_wdata = m_hwdata[32*i +: 32];
            end
        end
    end

    // hready[i]: own data phase (live or buffered) is done AND own address
    // phase, if any, is accepted this cycle. Idle masters therefore stay ready
    // even while the slave stalls.
    always_comb begin
        logic granted;
        logic dp_done;
        granted = 1'b0;
        dp_done = 1'b0;
        for (int unsigned i = 0; i < N_MASTERS; i++) begin
            live[i]    = dp_valid_q && (dp_owner_q == IDX_W'(i));
            granted    = accept && (gnt == IDX_W'(i));
            dp_done    = rsp_pending_q[i] || !live[i] || s_hready;
            hready[i]  = dp_done && (!req[i] || granted);
            buf_cap[i] = live[i] && s_hready && req[i] && !granted;

            if (rsp_pending_q[i]) begin
                m_hrdata[32*i +: 32] = rsp_data_q[i];
                m_hresp[i]           = rsp_err_q[i];
            end else if (live[i]) begin
                m_hrdata[32*i +: 32] = s_hrdata;
                m_hresp[i]           = s_hresp;
            end else begin
                m_hrdata[32*i +: 32] = '0;
                m_hresp[i]           = 1'b0;
            end
        end
    end

    assign m_hready    = hready;
    assign s_haddr     = gnt_valid ? sel_addr  : haddr_q;
    assign s_hwrite    = gnt_valid ? sel_write : hwrite_q;
    assign s_hsize     = gnt_valid ? sel_size  : hsize_q;
    assign s_htrans    = gnt_valid ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign s_hwdata    = dp_valid_q ? own_wdata : '0;
    assign s_hburst    = 3'b000;
    assign s_hmastlock = 1'b0;
    assign s_hprot     = 4'b0011;
    assign grant_idx   = gnt;

    always_comb begin
        dp_valid_d    = dp_valid_q;
        dp_owner_d    = dp_owner_q;
        rr_ptr_d      = rr_ptr_q;
        rsp_pending_d = rsp_pending_q;
        rsp_err_d     = rsp_err_q;
        rsp_data_d    = rsp_data_q;
        haddr_d       = s_haddr;
        hwrite_d      = s_hwrite;
        hsize_d       = s_hsize;
        if (s_hready) begin
            dp_valid_d = gnt_valid;
            if (gnt_valid) begin
                dp_owner_d = gnt;
                rr_ptr_d   = (gnt == IDX_W'(N_MASTERS-1)) ? '0 : gnt + IDX_W'(1);
            end
        end
        for (int unsigned i = 0; i < N_MASTERS; i++) begin
            if (buf_cap[i]) begin
                rsp_pending_d[i] = 1'b1;
                rsp_data_d[i]    = s_hrdata;
                rsp_err_d[i]     = s_hresp;
            end else if (accept && (gnt == IDX_W'(i))) begin
                rsp_pending_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dp_valid_q    <= 1'b0;
            dp_owner_q    <= '0;
            rr_ptr_q      <= '0;
            rsp_pending_q <= '0;
            rsp_err_q     <= '0;
            haddr_q       <= '0;
            hwrite_q      <= 1'b0;
            hsize_q       <= '0;
            for (int unsigned i = 0; i < N_MASTERS; i++) begin
                rsp_data_q[i] <= '0;
            end
        end else begin
            dp_valid_q    <= dp_valid_d;
            dp_owner_q    <= dp_owner_d;
            rr_ptr_q      <= rr_ptr_d;
            rsp_pending_q <= rsp_pending_d;
            rsp_err_q     <= rsp_err_d;
            rsp_data_q    <= rsp_data_d;
            haddr_q       <= haddr_d;
            hwrite_q      <= hwrite_d;
            hsize_q       <= hsize_d;
        end
    end

`ifdef VSCALE_HASTI_ARB_WAIT_CNT_EN
    logic [31:0] wait_cnt_q [N_MASTERS];
    logic [31:0] wait_cnt_d [N_MASTERS];

    // Counts stalled requesting cycles, also while the slave holds hready low.
    always_comb begin
        for (int unsigned i = 0; i < N_MASTERS; i++) begin
            wait_cnt_d[i] = wait_cnt_q[i];
            if (wait_cnt_clr) begin
                wait_cnt_d[i] = '0;
            end else if (req[i] && !hready[i] && (wait_cnt_q[i] != '1)) begin
                wait_cnt_d[i] = wait_cnt_q[i] + 32'd1;
            end
            wait_cnt[32*i +: 32] = wait_cnt_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < N_MASTERS; i++) begin
                wait_cnt_q[i] <= '0;
            end
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_vscale_hasti_arbiter.sv
module tb_vscale_hasti_arbiter;

    logic         clk;
    logic         reset;
    logic [127:0] m_haddr;
    logic [3:0]   m_hwrite;
    logic [11:0]  m_hsize;
    logic [7:0]   m_htrans;
    logic [127:0] m_hwdata;
    logic [127:0] m_hrdata;
    logic [3:0]   m_hready;
    logic [3:0]   m_hresp;
    logic [31:0]  s_haddr;
    logic         s_hwrite;
    logic [2:0]   s_hsize;
    logic [2:0]   s_hburst;
    logic         s_hmastlock;
    logic [3:0]   s_hprot;
    logic [1:0]   s_htrans;
    logic [31:0]  s_hwdata;
    logic [31:0]  s_hrdata;
    logic         s_hready;
    logic         s_hresp;
    logic [1:0]   grant_idx;

    int n_cmp;
    int n_fail;

    vscale_hasti_arbiter #(.N_MASTERS(4), .IDX_W(2)) dut (
        .clk(clk), .reset(reset),
        .m_haddr(m_haddr), .m_hwrite(m_hwrite), .m_hsize(m_hsize),
        .m_htrans(m_htrans), .m_hwdata(m_hwdata),
        .m_hrdata(m_hrdata), .m_hready(m_hready), .m_hresp(m_hresp),
        .s_haddr(s_haddr), .s_hwrite(s_hwrite), .s_hsize(s_hsize),
        .s_hburst(s_hburst), .s_hmastlock(s_hmastlock), .s_hprot(s_hprot),
        .s_htrans(s_htrans), .s_hwdata(s_hwdata),
        .s_hrdata(s_hrdata), .s_hready(s_hready), .s_hresp(s_hresp),
        .grant_idx(grant_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus helpers (no checking inside).
    task automatic idle_all();
        m_htrans = '0;
    endtask

    task automatic req_m(input int i, input logic [31:0] addr, input logic wr, input logic [31:0] wdata);
        m_htrans[2*i +: 2] = 2'b10;
        m_haddr[32*i +: 32] = addr;
        m_hwrite[i] = wr;
        m_hsize[3*i +: 3] = 3'd2;
        m_hwdata[32*i +: 32] = wdata;
    endtask

    task automatic slave(input logic rdy, input logic [31:0] rdata, input logic resp);
        s_hready = rdy;
        s_hrdata = rdata;
        s_hresp = resp;
    endtask

    // Drive new inputs at the falling edge; checks follow #1 later.
    task automatic cyc();
        @(negedge clk);
        idle_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        idle_all();
        m_haddr = '0; m_hwrite = '0; m_hsize = '0; m_hwdata = '0;
        slave(1'b1, 32'h0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_cmp++; if (s_htrans !== 2'b00) begin n_fail++; $display("FAIL rst_htrans: got %h want %h", s_htrans, 2'b00); end
        n_cmp++; if (s_haddr !== 32'h0) begin n_fail++; $display("FAIL rst_haddr: got %h want %h", s_haddr, 32'h0); end
        n_cmp++; if (s_hwrite !== 1'b0 || s_hsize !== 3'd0) begin n_fail++; $display("FAIL rst_ctrl: got %b/%h want 0/0", s_hwrite, s_hsize); end
        n_cmp++; if (grant_idx !== 2'd0) begin n_fail++; $display("FAIL rst_grant: got %0d want 0", grant_idx); end
        n_cmp++; if (m_hready !== 4'hF) begin n_fail++; $display("FAIL rst_hready: got %b want 1111", m_hready); end
        n_cmp++; if (m_hresp !== 4'h0) begin n_fail++; $display("FAIL rst_hresp: got %b want 0000", m_hresp); end
        n_cmp++; if (m_hrdata !== 128'h0) begin n_fail++; $display("FAIL rst_hrdata: got %h want 0", m_hrdata); end
        n_cmp++; if (s_hwdata !== 32'h0) begin n_fail++; $display("FAIL rst_hwdata: got %h want 0", s_hwdata); end
        n_cmp++; if (s_hburst !== 3'b000 || s_hmastlock !== 1'b0) begin n_fail++; $display("FAIL rst_const: got burst %b lock %b want 000 0", s_hburst, s_hmastlock); end
    endtask

    task automatic test_single_read();
        do_reset();
        cyc(); req_m(0, 32'h100, 1'b0, 32'h0); slave(1'b1, 32'h0, 1'b0); #1;
        n_cmp++; if (s_htrans !== 2'b10) begin n_fail++; $display("FAIL single_htrans: got %h want 2", s_htrans); end
        n_cmp++; if (s_haddr !== 32'h100) begin n_fail++; $display("FAIL single_haddr: got %h want 100", s_haddr); end
        n_cmp++; if (m_hready !== 4'hF) begin n_fail++; $display("FAIL single_hready_a: got %b want 1111", m_hready); end
        cyc(); slave(1'b1, 32'hDEADBEEF, 1'b0); #1;
        n_cmp++; if (m_hrdata[31:0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_rdata: got %h want deadbeef", m_hrdata[31:0]); end
        n_cmp++; if (m_hready !== 4'hF) begin n_fail++; $display("FAIL single_hready_d: got %b want 1111", m_hready); end
        n_cmp++; if (s_htrans !== 2'b00 || s_haddr !== 32'h100) begin n_fail++; $display("FAIL single_hold: got %h/%h want 0/100", s_htrans, s_haddr); end
        n_cmp++; if (m_hrdata[63:32] !== 32'h0) begin n_fail++; $display("FAIL single_other_rdata: got %h want 0", m_hrdata[63:32]); end
        cyc(); slave(1'b1, 32'h5555AAAA, 1'b0); #1;
        n_cmp++; if (m_hrdata[31:0] !== 32'h0) begin n_fail++; $display("FAIL single_no_dp: got %h want 0", m_hrdata[31:0]); end
    endtask

    task automatic test_round_robin();
        do_reset();
        cyc(); req_m(0, 32'h10, 1'b0, 32'h0); req_m(2, 32'h20, 1'b0, 32'h0); slave(1'b1, 32'h0, 1'b0); #1;
        n_cmp++; if (grant_idx !== 2'd0 || s_haddr !== 32'h10) begin n_fail++; $display("FAIL rr_a: got g%0d %h want g0 10", grant_idx, s_haddr); end
        n_cmp++; if (m_hready !== 4'b1011) begin n_fail++; $display("FAIL rr_a_rdy: got %b want 1011", m_hready); end
        cyc(); req_m(2, 32'h20, 1'b0, 32'h0); slave(1'b1, 32'h11110000, 1'b0); #1;
        n_cmp++; if (grant_idx !== 2'd2 || s_haddr !== 32'h20) begin n_fail++; $display("FAIL rr_b: got g%0d %h want g2 20", grant_idx, s_haddr); end
        n_cmp++; if (m_hready !== 4'hF || m_hrdata[31:0] !== 32'h11110000) begin n_fail++; $display("FAIL rr_b_rsp: got %b %h want 1111 11110000", m_hready, m_hrdata[31:0]); end
        cyc(); req_m(0, 32'h30, 1'b0, 32'h0); req_m(2, 32'h40, 1'b0, 32'h0); slave(1'b1, 32'h22220000, 1'b0); #1;
        n_cmp++; if (grant_idx !== 2'd0 || s_haddr !== 32'h30) begin n_fail++; $display("FAIL rr_c_wrap: got g%0d %h want g0 30", grant_idx, s_haddr); end
        n_cmp++; if (m_hready !== 4'b1011 || m_hrdata[95:64] !== 32'h22220000) begin n_fail++; $display("FAIL rr_c_rsp: got %b %h want 1011 22220000", m_hready, m_hrdata[95:64]); end
        cyc(); req_m(2, 32'h40, 1'b0, 32'h0); slave(1'b1, 32'h33330000, 1'b0); #1;
        n_cmp++; if (grant_idx !== 2'd2 || m_hready !== 4'hF) begin n_fail++; $display("FAIL rr_d: got g%0d %b want g2 1111", grant_idx, m_hready); end
        n_cmp++; if (m_hrdata[95:64] !== 32'h22220000 || m_hrdata[31:0] !== 32'h33330000) begin n_fail++; $display("FAIL rr_d_data: got %h %h want 22220000 33330000", m_hrdata[95:64], m_hrdata[31:0]); end
        cyc(); slave(1'b1, 32'h44440000, 1'b0); #1;
        n_cmp++; if (m_hrdata[95:64] !== 32'h44440000) begin n_fail++; $display("FAIL rr_e: got %h want 44440000", m_hrdata[95:64]); end
    endtask

    task automatic test_buffer();
        do_reset();
        cyc(); req_m(1, 32'h1000, 1'b0, 32'h0); slave(1'b1, 32'h0, 1'b0); #1;
        n_cmp++; if (grant_idx !== 2'd1) begin n_fail++; $display("FAIL buf_a: got g%0d want g1", grant_idx); end
        cyc(); req_m(1, 32'h1004, 1'b0, 32'h0); req_m(3, 32'h3000, 1'b0, 32'h0); slave(1'b1, 32'h12345678, 1'b0); #1;
        n_cmp++; if (grant_idx !== 2'd3 || m_hready !== 4'b1101) begin n_fail++; $display("FAIL buf_b: got g%0d %b want g3 1101", grant_idx, m_hready); end
        cyc(); req_m(1, 32'h1004, 1'b0, 32'h0); slave(1'b1, 32'h00009999, 1'b0); #1;
        n_cmp++; if (grant_idx !== 2'd1 || m_hready !== 4'hF) begin n_fail++; $display("FAIL buf_c: got g%0d %b want g1 1111", grant_idx, m_hready); end
        n_cmp++; if (m_hrdata[63:32] !== 32'h12345678) begin n_fail++; $display("FAIL buf_c_data: got %h want 12345678", m_hrdata[63:32]); end
        n_cmp++; if (m_hrdata[127:96] !== 32'h00009999) begin n_fail++; $display("FAIL buf_c_m3: got %h want 00009999", m_hrdata[127:96]); end
        cyc(); slave(1'b1, 32'hCAFEF00D, 1'b0); #1;
        n_cmp++; if (m_hrdata[63:32] !== 32'hCAFEF00D) begin n_fail++; $display("FAIL buf_released: got %h want cafef00d", m_hrdata[63:32]); end
    endtask

    task automatic test_error();
        do_reset();
        cyc(); req_m(2, 32'h2000, 1'b0, 32'h0); slave(1'b1, 32'h0, 1'b0); #1;
        cyc(); req_m(2, 32'h2004, 1'b0, 32'h0); req_m(0, 32'h0400, 1'b0, 32'h0); slave(1'b1, 32'h0, 1'b1); #1;
        n_cmp++; if (grant_idx !== 2'd0 || m_hready !== 4'b1011) begin n_fail++; $display("FAIL err_a: got g%0d %b want g0 1011", grant_idx, m_hready); end
        n_cmp++; if (m_hresp !== 4'b0100) begin n_fail++; $display("FAIL err_a_resp: got %b want 0100", m_hresp); end
        cyc(); req_m(2, 32'h2004, 1'b0, 32'h0); slave(1'b1, 32'h77, 1'b0); #1;
        n_cmp++; if (grant_idx !== 2'd2 || m_hready !== 4'hF) begin n_fail++; $display("FAIL err_b: got g%0d %b want g2 1111", grant_idx, m_hready); end
        n_cmp++; if (m_hresp !== 4'b0100 || m_hrdata[31:0] !== 32'h77) begin n_fail++; $display("FAIL err_b_resp: got %b %h want 0100 77", m_hresp, m_hrdata[31:0]); end
    endtask

    task automatic test_wait_store();
        do_reset();
        cyc(); req_m(0, 32'h200, 1'b1, 32'hA5A5A5A5); slave(1'b1, 32'h0, 1'b0); #1;
        n_cmp++; if (s_hwrite !== 1'b1 || s_haddr !== 32'h200 || m_hready !== 4'hF) begin n_fail++; $display("FAIL ws_a: got %b %h %b want 1 200 1111", s_hwrite, s_haddr, m_hready); end
        for (int w = 0; w < 3; w++) begin
            cyc(); m_hwdata[31:0] = 32'hA5A5A5A5; req_m(1, 32'h300, 1'b1, 32'h5A5A5A5A); slave(1'b0, 32'h0, 1'b0); #1;
            n_cmp++; if (s_hwdata !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL ws_wdata_%0d: got %h want a5a5a5a5", w, s_hwdata); end
            n_cmp++; if (m_hready !== 4'b1100) begin n_fail++; $display("FAIL ws_rdy_%0d: got %b want 1100", w, m_hready); end
        end
        cyc(); m_hwdata[31:0] = 32'hA5A5A5A5; req_m(1, 32'h300, 1'b1, 32'h5A5A5A5A); slave(1'b1, 32'h0, 1'b0); #1;
        n_cmp++; if (s_hwdata !== 32'hA5A5A5A5 || m_hready !== 4'hF) begin n_fail++; $display("FAIL ws_done: got %h %b want a5a5a5a5 1111", s_hwdata, m_hready); end
        cyc(); slave(1'b1, 32'h0, 1'b0); #1;
        n_cmp++; if (s_hwdata !== 32'h5A5A5A5A) begin n_fail++; $display("FAIL ws_m1_wdata: got %h want 5a5a5a5a", s_hwdata); end
        cyc(); slave(1'b1, 32'h0, 1'b0); #1;
        n_cmp++; if (s_hwdata !== 32'h0) begin n_fail++; $display("FAIL ws_idle_wdata: got %h want 0", s_hwdata); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            cyc();
            if (k < 3) req_m(0, 32'(4*k), 1'b0, 32'h0);
            slave(1'b1, 32'h100 + 32'(k), 1'b0); #1;
            n_cmp++; if (m_hready[0] !== 1'b1) begin n_fail++; $display("FAIL b2b_rdy_%0d: got %b want 1", k, m_hready[0]); end
            if (k > 0) begin
                n_cmp++; if (m_hrdata[31:0] !== 32'h100 + 32'(k)) begin n_fail++; $display("FAIL b2b_data_%0d: got %h want %h", k, m_hrdata[31:0], 32'h100 + 32'(k)); end
            end
        end
    endtask

    task automatic test_fairness();
        do_reset();
        for (int k = 0; k < 8; k++) begin
            cyc();
            for (int i = 0; i < 4; i++) req_m(i, 32'h8000 + 32'(16*i + k), 1'b0, 32'h0);
            slave(1'b1, 32'(k), 1'b0); #1;
            n_cmp++; if (grant_idx !== 2'(k % 4)) begin n_fail++; $display("FAIL fair_grant_%0d: got %0d want %0d", k, grant_idx, k % 4); end
            n_cmp++; if (m_hready !== 4'(1 << (k % 4))) begin n_fail++; $display("FAIL fair_rdy_%0d: got %b want %b", k, m_hready, 4'(1 << (k % 4))); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        cyc(); req_m(1, 32'h1000, 1'b0, 32'h0); slave(1'b1, 32'h0, 1'b0); #1;
        cyc(); req_m(1, 32'h1004, 1'b0, 32'h0); req_m(3, 32'h3000, 1'b0, 32'hBBBB0000); slave(1'b1, 32'h12345678, 1'b0); #1;
        cyc(); req_m(1, 32'h1004, 1'b0, 32'h0); m_hwdata[127:96] = 32'hBBBB0000; slave(1'b0, 32'h0, 1'b0); #1;
        n_cmp++; if (m_hrdata[63:32] !== 32'h12345678 || m_hready[1] !== 1'b0) begin n_fail++; $display("FAIL rm_pending: got %h %b want 12345678 0", m_hrdata[63:32], m_hready[1]); end
        reset = 1'b1;
        cyc(); reset = 1'b0; slave(1'b1, 32'h0, 1'b0); #1;
        n_cmp++; if (s_htrans !== 2'b00 || m_hready !== 4'hF) begin n_fail++; $display("FAIL rm_idle: got %h %b want 0 1111", s_htrans, m_hready); end
        n_cmp++; if (m_hrdata[63:32] !== 32'h0 || s_hwdata !== 32'h0) begin n_fail++; $display("FAIL rm_flushed: got %h %h want 0 0", m_hrdata[63:32], s_hwdata); end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        reset = 1'b1;
        m_haddr = '0; m_hwrite = '0; m_hsize = '0; m_htrans = '0; m_hwdata = '0;
        s_hready = 1'b1; s_hrdata = '0; s_hresp = 1'b0;
        test_reset();
        test_single_read();
        test_round_robin();
        test_buffer();
        test_error();
        test_wait_store();
        test_back_to_back();
        test_fairness();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
